// File: rtl/ps2_key_event_encoder.sv
// Device-side PS/2 keyboard emulator: serialises one key event into [E0] [F0] code frames,
// generating the PS/2 clock itself. Define PS2_BAT_EN to send a 0xAA BAT byte after reset.
module ps2_key_event_encoder #(
   parameter int HALF_CYC = 4000,
   parameter int GAP_CYC  = 40000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [7:0] ev_code,
   input  logic       ev_extend,
   input  logic       ev_break,
   input  logic       ps2_clk_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       ev_done
);

   localparam int MAX_CYC = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [3:0]       STOP_BIT  = 4'd10;

`ifdef PS2_BAT_EN
   localparam logic BAT_EN = 1'b1;
`else
   localparam logic BAT_EN = 1'b0;
`endif

   localparam logic [2:0] ST_INIT = 3'd0;
   localparam logic [2:0] ST_IDLE = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_HIGH = 3'd3;
   localparam logic [2:0] ST_LOW  = 3'd4;
   localparam logic [2:0] ST_GAP  = 3'd5;

   logic [2:0]       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       bit_idx, bit_n;
   logic             ext_q, ext_n;
   logic             brk_q, brk_n;
   logic             bat_q, bat_n;
   logic             last_q, last_n;
   logic             done_n;
   logic             accept;
   logic [7:0]       code_q;
   logic [7:0]       cur_byte;
   logic             in_frame_n;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
      logic [3:0] d_idx;
      d_idx = idx - 4'd1;
      if (idx == 4'd0)
         return 1'b0;
      else if (idx <= 4'd8)
         return data[d_idx[2:0]];
      else if (idx == 4'd9)
         return odd_parity(data);
      else
         return 1'b1;
   endfunction

   // Pending prefixes are consumed in order; the byte on the wire is always the oldest one left.
   always_comb begin
      if (bat_q)
         cur_byte = 8'hAA;
      else if (ext_q)
         cur_byte = 8'hE0;
      else if (brk_q)
         cur_byte = 8'hF0;
      else
         cur_byte = code_q;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      ext_n   = ext_q;
      brk_n   = brk_q;
      bat_n   = bat_q;
      last_n  = last_q;
      done_n  = 1'b0;
      accept  = 1'b0;
      case (state)
         ST_INIT: begin
            cnt_n  = '0;
            bat_n  = BAT_EN;
            last_n = 1'b0;
            state_n = BAT_EN ? ST_WAIT : ST_IDLE;
         end
         ST_IDLE: begin
            if (ev_valid) begin
               accept  = 1'b1;
               ext_n   = ev_extend;
               brk_n   = ev_break;
               last_n  = 1'b0;
               cnt_n   = '0;
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!ps2_clk_in) begin
               cnt_n = '0;
            end else if (cnt == HALF_LAST) begin
               cnt_n   = '0;
               bit_n   = 4'd0;
               state_n = ST_HIGH;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               // Host holding the clock low at the end of a HIGH phase inhibits us: restart the byte.
               if (!ps2_clk_in) begin
                  bit_n   = 4'd0;
                  state_n = ST_WAIT;
               end else begin
                  state_n = ST_LOW;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_LOW: begin
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               if (bit_idx == STOP_BIT) begin
                  state_n = ST_GAP;
                  if (bat_q)
                     last_n = 1'b1;
                  else if (ext_q)
                     ext_n = 1'b0;
                  else if (brk_q)
                     brk_n = 1'b0;
                  else
                     last_n = 1'b1;
               end else begin
                  bit_n   = bit_idx + 4'd1;
                  state_n = ST_HIGH;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n = '0;
               if (last_q) begin
                  done_n  = !bat_q;
                  bat_n   = 1'b0;
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_WAIT;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = ST_IDLE;
         end
      endcase
   end

   assign in_frame_n = (state_n == ST_HIGH) || (state_n == ST_LOW);

   // Line drivers are registered from the next state so the open-drain enables never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_INIT;
         cnt         <= '0;
         bit_idx     <= 4'd0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         bat_q       <= 1'b0;
         last_q      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         ev_done     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bit_idx     <= bit_n;
         ext_q       <= ext_n;
         brk_q       <= brk_n;
         bat_q       <= bat_n;
         last_q      <= last_n;
         ps2_clk_oe  <= (state_n == ST_LOW);
         ps2_data_oe <= in_frame_n && !frame_bit(cur_byte, bit_n);
         ev_done     <= done_n;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         code_q <= ev_code;
   end

   assign ev_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE) && (state != ST_INIT);

endmodule

// File: tb/tb_ps2_key_event_encoder.sv
// Directed bench for ps2_key_event_encoder: a table of key events plus hand-written
// inhibit, held-valid and mid-frame-reset sequences, checked against hand-computed frames.
`timescale 1ns/1ps
module tb_ps2_key_event_encoder;

   localparam int HALF = 4;
   localparam int GAP  = 12;

   // Expected data_oe per frame bit, bit i of the vector = frame bit i (start first).
   localparam logic [10:0] FR_1C = 11'b01111000111;
   localparam logic [10:0] FR_F0 = 11'b00000011111;
   localparam logic [10:0] FR_E0 = 11'b01000111111;
   localparam logic [10:0] FR_75 = 11'b01100010101;
   localparam logic [10:0] FR_2A = 11'b01110101011;
   localparam logic [10:0] FR_5A = 11'b00101001011;
`ifdef PS2_BAT_EN
   localparam logic [10:0] FR_AA = 11'b00010101011;
`endif

   typedef struct {
      logic             ext;
      logic             brk;
      logic [7:0]       code;
      int               nfr;
      logic [2:0][10:0] fr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ev_valid = 1'b0;
   logic       ev_extend = 1'b0;
   logic       ev_break = 1'b0;
   logic [7:0] ev_code = 8'h00;
   logic       force_low = 1'b0;
   logic       ev_ready, ps2_clk_in, ps2_clk_oe, ps2_data_oe, busy, ev_done;

   assign ps2_clk_in = ~(ps2_clk_oe | force_low);

   always #5 clk = ~clk;

   ps2_key_event_encoder #(.HALF_CYC(HALF), .GAP_CYC(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_extend  (ev_extend),
      .ev_break   (ev_break),
      .ps2_clk_in (ps2_clk_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .ev_done    (ev_done)
   );

   int nvec = 0;
   int nerr = 0;

   // Host-side frame capture: samples data on each PS/2 clock falling edge.
   logic [10:0] fr_buf [0:63];
   int          fr_gap [0:63];
   int          fr_wr = 0;
   int          aborts = 0;
   int          dones = 0;
   int          mon_err = 0;
   int          zrun = 0;
   int          orun = 0;
   int          bcnt = 0;
   int          gap_len = 0;
   logic [10:0] shf = '0;
   logic        held = 1'b0;
   logic        prev_oe = 1'b0;
   logic        prev_done = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         bcnt = 0;
         zrun = 0;
         orun = 0;
         prev_oe = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (ev_done) begin
            dones++;
            if (prev_done) mon_err++;
         end
         prev_done = ev_done;
         if (ps2_clk_oe && !prev_oe) begin
            if (zrun > HALF) begin
               if (bcnt != 0) aborts++;
               bcnt = 0;
               gap_len = zrun;
            end else if (bcnt == 0 || zrun != HALF) begin
               mon_err++;
            end
            shf[bcnt] = ps2_data_oe;
            held = ps2_data_oe;
            bcnt++;
            if (bcnt == 11) begin
               fr_buf[fr_wr] = shf;
               fr_gap[fr_wr] = gap_len;
               if (fr_wr < 63) fr_wr++;
               bcnt = 0;
            end
            orun = 1;
            zrun = 0;
         end else if (ps2_clk_oe) begin
            orun++;
            if (ps2_data_oe != held) mon_err++;
         end else if (prev_oe) begin
            if (orun != HALF) mon_err++;
            orun = 0;
            zrun = 1;
         end else begin
            zrun++;
         end
         prev_oe = ps2_clk_oe;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
`ifdef PS2_BAT_EN
      int f0, d0, cyc;
`endif
      rst = 1'b1;
      #1;
      chk("rst_outputs", int'({ps2_clk_oe, ps2_data_oe, ev_ready, busy, ev_done}), 0);
      tick;
      tick;
      rst = 1'b0;
      chk("rst_ready_before_edge", int'(ev_ready), 0);
      tick;
`ifdef PS2_BAT_EN
      chk("bat_busy", int'({ev_ready, busy}), 1);
      f0 = fr_wr;
      d0 = dones;
      cyc = 0;
      while (!ev_ready && cyc < 2000) begin
         tick;
         cyc++;
      end
      chk("bat_ready", int'(ev_ready), 1);
      chk("bat_frames", fr_wr - f0, 1);
      chk("bat_frame", int'(fr_buf[f0]), int'(FR_AA));
      chk("bat_no_done", dones - d0, 0);
`else
      chk("rst_ready_first_cycle", int'({ev_ready, busy}), 2);
`endif
   endtask

   task automatic run_event(input logic e, input logic b, input logic [7:0] c, input int nfr,
                            input logic [2:0][10:0] exp, input string tag);
      int f0, d0, cyc;
      f0 = fr_wr;
      d0 = dones;
      cyc = 0;
      while (!ev_ready && cyc < 1000) begin
         tick;
         cyc++;
      end
      chk({tag, "_ready"}, int'(ev_ready), 1);
      ev_valid = 1'b1;
      ev_extend = e;
      ev_break = b;
      ev_code = c;
      tick;
      ev_valid = 1'b0;
      ev_extend = ~e;
      ev_break = ~b;
      ev_code = ~c;
      chk({tag, "_accept"}, int'({ev_ready, busy}), 1);
      cyc = 0;
      while (!ps2_data_oe && cyc < 10 * HALF) begin
         tick;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, HALF);
      cyc = 0;
      while (!ev_done && cyc < 4000) begin
         tick;
         cyc++;
      end
      chk({tag, "_done"}, int'({ev_done, ev_ready}), 3);
      tick;
      chk({tag, "_pulse"}, int'(ev_done), 0);
      chk({tag, "_nframes"}, fr_wr - f0, nfr);
      for (int i = 0; i < nfr; i++) begin
         chk($sformatf("%s_frame%0d", tag, i), int'(fr_buf[f0 + i]), int'(exp[i]));
         if (i > 0) chk($sformatf("%s_gap%0d", tag, i), fr_gap[f0 + i], GAP + 2 * HALF);
      end
      chk({tag, "_ndone"}, dones - d0, 1);
   endtask

   vec_t vecs [5];
   int   f0, d0, a0, cyc, rdy_seen, clk_seen;

   initial begin
      vecs[0] = '{ext: 1'b0, brk: 1'b0, code: 8'h1C, nfr: 1, fr: {11'd0, 11'd0, FR_1C}};
      vecs[1] = '{ext: 1'b0, brk: 1'b1, code: 8'h1C, nfr: 2, fr: {11'd0, FR_1C, FR_F0}};
      vecs[2] = '{ext: 1'b1, brk: 1'b1, code: 8'h75, nfr: 3, fr: {FR_75, FR_F0, FR_E0}};
      vecs[3] = '{ext: 1'b1, brk: 1'b0, code: 8'h5A, nfr: 2, fr: {11'd0, FR_5A, FR_E0}};
      vecs[4] = '{ext: 1'b0, brk: 1'b1, code: 8'h2A, nfr: 2, fr: {11'd0, FR_2A, FR_F0}};

      repeat (2) @(negedge clk);
      do_reset;

      for (int v = 0; v < 5; v++)
         run_event(vecs[v].ext, vecs[v].brk, vecs[v].code, vecs[v].nfr, vecs[v].fr,
                   $sformatf("vec%0d", v));

      // Event offered again while busy: must wait for ev_done, then go on the first IDLE cycle.
      f0 = fr_wr;
      ev_valid = 1'b1;
      ev_extend = 1'b0;
      ev_break = 1'b0;
      ev_code = 8'h1C;
      tick;
      ev_code = 8'h2A;
      chk("hold_accept", int'({ev_ready, busy}), 1);
      rdy_seen = 0;
      cyc = 0;
      while (!ev_done && cyc < 2000) begin
         tick;
         cyc++;
         if (ev_ready && !ev_done) rdy_seen++;
      end
      chk("hold_no_early_ready", rdy_seen, 0);
      chk("hold_ready_at_done", int'({ev_done, ev_ready}), 3);
      tick;
      ev_valid = 1'b0;
      chk("hold_taken_first_idle", int'({ev_ready, busy, ev_done}), 2);
      cyc = 0;
      while (!ev_done && cyc < 2000) begin
         tick;
         cyc++;
      end
      chk("hold_second_done", int'(ev_done), 1);
      chk("hold_nframes", fr_wr - f0, 2);
      chk("hold_frame0", int'(fr_buf[f0]), int'(FR_1C));
      chk("hold_frame1", int'(fr_buf[f0 + 1]), int'(FR_2A));

      // Host inhibit during HIGH of data bit 5 of the F0 byte.
      f0 = fr_wr;
      d0 = dones;
      a0 = aborts;
      tick;
      ev_valid = 1'b1;
      ev_extend = 1'b1;
      ev_break = 1'b1;
      ev_code = 8'h75;
      tick;
      ev_valid = 1'b0;
      cyc = 0;
      while (!((fr_wr - f0 == 1) && bcnt == 6 && !ps2_clk_oe) && cyc < 3000) begin
         tick;
         cyc++;
      end
      chk("inh_reached_bit6", int'((fr_wr - f0 == 1) && bcnt == 6), 1);
      force_low = 1'b1;
      repeat (HALF) tick;
      chk("inh_lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
      clk_seen = 0;
      repeat (3 * HALF) begin
         tick;
         if (ps2_clk_oe || ps2_data_oe) clk_seen++;
      end
      chk("inh_stay_released", clk_seen, 0);
      force_low = 1'b0;
      cyc = 0;
      while (!ps2_data_oe && cyc < 10 * HALF) begin
         tick;
         cyc++;
      end
      chk("inh_resend_latency", cyc, HALF);
      cyc = 0;
      while (!ev_done && cyc < 4000) begin
         tick;
         cyc++;
      end
      chk("inh_done", int'(ev_done), 1);
      chk("inh_nframes", fr_wr - f0, 3);
      chk("inh_frame0", int'(fr_buf[f0]), int'(FR_E0));
      chk("inh_frame1", int'(fr_buf[f0 + 1]), int'(FR_F0));
      chk("inh_frame2", int'(fr_buf[f0 + 2]), int'(FR_75));
      chk("inh_aborts", aborts - a0, 1);
      chk("inh_ndone", dones - d0 + 1, 2);

      // Reset asserted during LOW of bit 3 must release both lines at once.
      tick;
      f0 = fr_wr;
      d0 = dones;
      ev_valid = 1'b1;
      ev_extend = 1'b0;
      ev_break = 1'b0;
      ev_code = 8'h2A;
      tick;
      ev_valid = 1'b0;
      cyc = 0;
      while (!(bcnt == 4 && ps2_clk_oe) && cyc < 2000) begin
         tick;
         cyc++;
      end
      chk("mrst_bit3_low", int'({ps2_clk_oe, ps2_data_oe}), 3);
      do_reset;
      repeat (GAP + 4 * HALF) tick;
      chk("mrst_no_frame", fr_wr - f0, 0);
      chk("mrst_no_done", dones - d0, 0);
      chk("mrst_idle", int'({ev_ready, busy, ps2_clk_oe}), 4);

      run_event(1'b0, 1'b0, 8'h5A, 1, {11'd0, 11'd0, FR_5A}, "post_rst");

      chk("monitor_errors", mon_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
